// File: rtl/move_input_ctrl.sv
// Push-button front end for the 2048 game: synchronizes and debounces five raw
// active-low buttons, issues one-shot move/start commands and tracks move history.
module move_input_ctrl #(
    parameter int DB_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_left_n,
    input  logic       btn_right_n,
    input  logic       btn_up_n,
    input  logic       btn_down_n,
    input  logic       btn_start_n,
    input  logic       en,
    output logic       mov_left,
    output logic       mov_right,
    output logic       mov_up,
    output logic       mov_down,
    output logic       start,
    output logic [1:0] last_dir,
    output logic [7:0] move_count,
    output logic [1:0] fsm_state
);

    localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FIRE     = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    // Bit order: 0 left, 1 right, 2 up, 3 down, 4 start (matches direction codes).
    logic [4:0]    raw;
    logic [4:0]    sync1;
    logic [4:0]    sync2;
    logic [4:0]    db;
    logic [CW-1:0] cnt [5];

    assign raw = {btn_start_n, btn_down_n, btn_up_n, btn_right_n, btn_left_n};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // The counter is cleared by any sample that agrees with the debounced level,
    // so only DB_CYCLES uninterrupted disagreeing samples flip the level.
    for (genvar i = 0; i < 5; i++) begin : g_db
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt[i] <= '0;
                db[i]  <= 1'b1;
            end else if (sync2[i] == db[i]) begin
                cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
                cnt[i] <= '0;
                db[i]  <= ~db[i];
            end else begin
                cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    state_t     state;
    state_t     state_next;
    logic [1:0] dir_q;
    logic [1:0] dir_next;
    logic [3:0] pressed;
    logic       fire_entry;
    logic       start_prev;

    assign pressed    = ~db[3:0];
    assign fire_entry = (state == IDLE) && (state_next == FIRE);
    assign fsm_state  = state;

    always_comb begin
        state_next = state;
        dir_next   = dir_q;
        case (state)
            IDLE: begin
                if (en && (pressed != 4'b0000)) begin
                    state_next = FIRE;
                    if (pressed[0])      dir_next = 2'd0;
                    else if (pressed[1]) dir_next = 2'd1;
                    else if (pressed[2]) dir_next = 2'd2;
                    else                 dir_next = 2'd3;
                end
            end
            FIRE:     state_next = WAIT_REL;
            WAIT_REL: if (pressed == 4'b0000) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Command outputs are registered from the next-state decode so they are
    // low exactly during the FIRE cycle without a combinational output path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            dir_q      <= 2'd0;
            mov_left   <= 1'b1;
            mov_right  <= 1'b1;
            mov_up     <= 1'b1;
            mov_down   <= 1'b1;
            last_dir   <= 2'd0;
            move_count <= 8'd0;
            start_prev <= 1'b1;
            start      <= 1'b1;
        end else begin
            state      <= state_next;
            dir_q      <= dir_next;
            mov_left   <= !(fire_entry && (dir_next == 2'd0));
            mov_right  <= !(fire_entry && (dir_next == 2'd1));
            mov_up     <= !(fire_entry && (dir_next == 2'd2));
            mov_down   <= !(fire_entry && (dir_next == 2'd3));
            if (fire_entry) begin
                last_dir   <= dir_next;
                move_count <= move_count + 8'd1;
            end
            start_prev <= db[4];
            start      <= !(start_prev && !db[4]);
        end
    end

endmodule

// File: tb/tb_move_input_ctrl.sv
// Directed bench for move_input_ctrl with DB_CYCLES=4; edge numbers in each
// window count rising edges after the stimulus change.
module tb_move_input_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_left_n, btn_right_n, btn_up_n, btn_down_n, btn_start_n;
    logic       en;
    logic       mov_left, mov_right, mov_up, mov_down, start;
    logic [1:0] last_dir;
    logic [7:0] move_count;
    logic [1:0] fsm_state;

    int vec_cnt = 0;
    int err_cnt = 0;

    move_input_ctrl #(.DB_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .btn_left_n(btn_left_n), .btn_right_n(btn_right_n),
        .btn_up_n(btn_up_n), .btn_down_n(btn_down_n), .btn_start_n(btn_start_n),
        .en(en),
        .mov_left(mov_left), .mov_right(mov_right), .mov_up(mov_up), .mov_down(mov_down),
        .start(start), .last_dir(last_dir), .move_count(move_count), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    // Moves to 1 time unit after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Outputs as {left,right,up,down}; pulse_k = edge where exp_pulse appears (0 = none).
    task automatic check_window(input string name, input int n, input int pulse_k,
                                input logic [3:0] exp_pulse);
        logic [3:0] exp;
        logic [3:0] got;
        for (int k = 1; k <= n; k++) begin
            tick();
            exp = (k == pulse_k) ? exp_pulse : 4'b1111;
            got = {mov_left, mov_right, mov_up, mov_down};
            vec_cnt++;
            if (got !== exp) begin
                err_cnt++;
                $display("FAIL %s edge %0d: mov=%b expected %b", name, k, got, exp);
            end
        end
    endtask

    task automatic release_all(input string name);
        {btn_left_n, btn_right_n, btn_up_n, btn_down_n, btn_start_n} = 5'b11111;
        check_window(name, 10, 0, 4'b1111);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        {btn_left_n, btn_right_n, btn_up_n, btn_down_n, btn_start_n} = 5'b11111;
        en = 1'b1;
        #12;
        vec_cnt++;
        if ({mov_left, mov_right, mov_up, mov_down, start, last_dir, move_count, fsm_state}
            !== {5'b11111, 2'd0, 8'd0, 2'd0}) begin
            err_cnt++;
            $display("FAIL reset: outs=%b dir=%0d cnt=%0d st=%0d expected 11111/0/0/0",
                     {mov_left, mov_right, mov_up, mov_down, start}, last_dir, move_count, fsm_state);
        end
        tick();
        reset = 1'b1;
        check_window("reset_idle", 3, 0, 4'b1111);
    endtask

    task automatic test_clean_press;
        btn_up_n = 1'b0;
        check_window("clean_press", 14, 7, 4'b1101);
        vec_cnt++;
        if (move_count !== 8'd1 || last_dir !== 2'd2) begin
            err_cnt++;
            $display("FAIL clean_press_regs: cnt=%0d dir=%0d expected 1/2", move_count, last_dir);
        end
        release_all("clean_release");
    endtask

    task automatic test_bounce;
        btn_left_n = 1'b0;
        tick(); tick(); tick();
        btn_left_n = 1'b1;
        tick();
        btn_left_n = 1'b0;
        // Steady low starts here; pulse expected 7 edges later.
        check_window("bounce", 12, 7, 4'b0111);
        vec_cnt++;
        if (move_count !== 8'd2 || last_dir !== 2'd0) begin
            err_cnt++;
            $display("FAIL bounce_regs: cnt=%0d dir=%0d expected 2/0", move_count, last_dir);
        end
        release_all("bounce_release");
    endtask

    task automatic test_simultaneous;
        btn_right_n = 1'b0;
        btn_down_n  = 1'b0;
        check_window("simul_right", 12, 7, 4'b1011);
        release_all("simul_release");
        btn_down_n = 1'b0;
        check_window("simul_down", 12, 7, 4'b1110);
        vec_cnt++;
        if (move_count !== 8'd4 || last_dir !== 2'd3) begin
            err_cnt++;
            $display("FAIL simul_regs: cnt=%0d dir=%0d expected 4/3", move_count, last_dir);
        end
        release_all("simul_release2");
    endtask

    task automatic test_enable;
        en = 1'b0;
        btn_left_n = 1'b0;
        check_window("enable_blocked", 12, 0, 4'b1111);
        en = 1'b1;
        check_window("enable_fire", 6, 1, 4'b0111);
        vec_cnt++;
        if (move_count !== 8'd5) begin
            err_cnt++;
            $display("FAIL enable_count: cnt=%0d expected 5", move_count);
        end
        release_all("enable_release");
    endtask

    task automatic test_wrap;
        logic [3:0] btns;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        tick();
        for (int i = 0; i < 256; i++) begin
            btns = ~(4'b0001 << (i % 4));
            {btn_down_n, btn_up_n, btn_right_n, btn_left_n} = btns;
            repeat (9) tick();
            {btn_down_n, btn_up_n, btn_right_n, btn_left_n} = 4'b1111;
            repeat (9) tick();
            if (i == 254) begin
                vec_cnt++;
                if (move_count !== 8'd255 || last_dir !== 2'd2) begin
                    err_cnt++;
                    $display("FAIL wrap_255: cnt=%0d dir=%0d expected 255/2", move_count, last_dir);
                end
            end
        end
        vec_cnt++;
        if (move_count !== 8'd0 || last_dir !== 2'd3) begin
            err_cnt++;
            $display("FAIL wrap_0: cnt=%0d dir=%0d expected 0/3", move_count, last_dir);
        end
    endtask

    task automatic test_start;
        logic exp;
        en = 1'b0;
        btn_start_n = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp = (k == 7) ? 1'b0 : 1'b1;
            vec_cnt++;
            if (start !== exp || {mov_left, mov_right, mov_up, mov_down} !== 4'b1111) begin
                err_cnt++;
                $display("FAIL start edge %0d: start=%b mov=%b expected %b/1111",
                         k, start, {mov_left, mov_right, mov_up, mov_down}, exp);
            end
        end
        en = 1'b1;
        release_all("start_release");
    endtask

    task automatic test_reset_mid_fire;
        btn_down_n = 1'b0;
        check_window("midfire_pre", 7, 7, 4'b1110);
        vec_cnt++;
        if (move_count !== 8'd1) begin
            err_cnt++;
            $display("FAIL midfire_count_pre: cnt=%0d expected 1", move_count);
        end
        #1;
        reset = 1'b0;
        #1;
        vec_cnt++;
        if (mov_down !== 1'b1 || move_count !== 8'd0) begin
            err_cnt++;
            $display("FAIL midfire_reset: mov_down=%b cnt=%0d expected 1/0", mov_down, move_count);
        end
        #10;
        reset = 1'b1;
        // Button still held: must be debounced again from the released level.
        check_window("midfire_after", 12, 7, 4'b1110);
        release_all("midfire_release");
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_enable();
        test_wrap();
        test_start();
        test_reset_mid_fire();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/move_input_ctrl.md
MOVE_INPUT_CTRL -- requirements
Module: move_input_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 16, consecutive stable cycles required to accept a debounced level change (legal range 2..65535).
REQ-002 clk  input  1  system clock; all state changes occur on its rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-low.
REQ-004 btn_left_n, btn_right_n, btn_up_n, btn_down_n  input  1 each  raw asynchronous push-buttons, active-low.
REQ-005 btn_start_n  input  1  raw asynchronous start push-button, active-low.
REQ-006 en  input  1  active-high enable for direction commands; when low, no new direction pulse is issued.
REQ-007 mov_left, mov_right, mov_up, mov_down  output  1 each  active-low one-cycle move commands to the 2048 game FSM.
REQ-008 start  output  1  active-low one-cycle start command to the game FSM.
REQ-009 last_dir  output  2  last issued direction (0 left, 1 right, 2 up, 3 down).
REQ-010 move_count  output  8  count of issued direction pulses.

Function
REQ-011 Each of the five raw inputs SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Each synchronized input SHALL feed its own debouncer: a counter clears whenever the sample equals the debounced level and increments otherwise; the debounced level SHALL toggle on the edge where the counter reaches DB_CYCLES, and the counter SHALL clear on that same edge.
REQ-013 A bounce (sample returning to the debounced level) before DB_CYCLES is reached SHALL clear the counter with no change to the debounced level.
REQ-014 The direction FSM SHALL have three states: IDLE, FIRE, WAIT_REL.
REQ-015 IDLE -> FIRE when en=1 and at least one debounced direction is pressed; the chosen direction SHALL be latched on that edge.
REQ-016 Simultaneous presses SHALL be resolved by fixed priority: left > right > up > down.
REQ-017 In FIRE, exactly the latched mov_* output SHALL be 0 for exactly one cycle; all other mov_* outputs SHALL be 1; FIRE -> WAIT_REL unconditionally.
REQ-018 On the FIRE edge, last_dir SHALL load the latched code and move_count SHALL increment modulo 256 (255 wraps to 0).
REQ-019 WAIT_REL -> IDLE only when all four debounced directions are released; a held button or a second button pressed while held SHALL produce no further pulse (no auto-repeat).
REQ-020 en=0 SHALL block only IDLE -> FIRE; a FIRE already entered SHALL complete.
REQ-021 start SHALL be 0 for exactly one cycle, one cycle after the debounced start level goes from released to pressed, independent of en and of the direction FSM state.
REQ-022 Latency from a clean raw press to the active output cycle SHALL be 2 + DB_CYCLES + 1 clock edges.
REQ-023 All outputs SHALL be driven from registers (no combinational path from inputs).

Reset
REQ-024 While reset=0: synchronizer flops and debounced levels = 1 (released); debounce counters = 0; FSM = IDLE.
REQ-025 While reset=0: mov_left = mov_right = mov_up = mov_down = 1, start = 1, last_dir = 0, move_count = 0.
REQ-026 Reset asserted mid-FIRE SHALL immediately force the mov_* outputs to 1; after release, a button still held SHALL produce a pulse only once it has been debounced again from the released level.

Verification (DB_CYCLES=4)
REQ-027 Clean press: btn_up_n held low from edge 0 -> mov_up=0 for the single cycle after edge 7; move_count=1; last_dir=2; no further pulse while held.
REQ-028 Bounce: btn_left_n low 3 cycles, high 1 cycle, then low steady -> no pulse during the bounce; one mov_left pulse 7 edges after the steady low begins.
REQ-029 Simultaneous: btn_right_n and btn_down_n fall on the same edge -> only mov_right pulses; after both are released and down is re-pressed, mov_down pulses.
REQ-030 Enable: en=0 while btn_left_n is held -> no pulse; en goes high while btn_left_n is still held -> mov_left pulses one cycle later.
REQ-031 Wrap and start: 256 press/release cycles -> move_count returns to 0; btn_start_n press -> start=0 for one cycle regardless of en.
REQ-032 Reset mid-FIRE: reset=0 during the mov_down=0 cycle -> mov_down=1 immediately and move_count=0.
